// File: rtl/io_bus_ctrl_pkg.sv
// Shared constants and register decode for the memory-mapped IO controller.
package io_bus_ctrl_pkg;

  localparam int unsigned IO_DW      = 24;
  localparam logic [7:0]  LED_OFS    = 8'h60;
  localparam logic [7:0]  SW_OFS     = 8'h70;
  localparam logic [7:0]  STATUS_OFS = 8'h74;
  localparam logic [21:0] IO_BASE    = 22'h3FFFFF;

  typedef enum logic [1:0] {
    RegLed,
    RegSwitch,
    RegStatus,
    RegNone
  } io_reg_e;

  function automatic io_reg_e decode_ofs(input logic [7:0] ofs);
    io_reg_e sel;
    case (ofs)
      LED_OFS:    sel = RegLed;
      SW_OFS:     sel = RegSwitch;
      STATUS_OFS: sel = RegStatus;
      default:    sel = RegNone;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/io_bus_ctrl_switch_debounce.sv
// Two-flop synchroniser plus stability counter; a vector is accepted only after
// it has been seen unchanged for CYCLES consecutive cycles.
module switch_debounce #(
  parameter int unsigned WIDTH  = 24,
  parameter int unsigned CYCLES = 500000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] stable,
  output logic             changed_pulse
);

  localparam int unsigned CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CYCLES - 1);

  logic [WIDTH-1:0] sync1_q, sync2_q, cand_q, stable_q;
  logic [CW-1:0]    cnt_q;

  always_comb begin
    changed_pulse = (sync2_q == cand_q) && (cnt_q == CNT_MAX) && (stable_q != cand_q);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      cand_q   <= '0;
      stable_q <= '0;
      cnt_q    <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      if (sync2_q != cand_q) begin
        cand_q <= sync2_q;
        cnt_q  <= '0;
      end else if (cnt_q == CNT_MAX) begin
        // Counter saturates; stable only moves when the candidate differs.
        if (changed_pulse) stable_q <= cand_q;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign stable = stable_q;

endmodule

// File: rtl/io_bus_ctrl.sv
// IO device controller: address decode, LED register, debounced switches and a
// sticky switch-change flag cleared by reading the status register.
module io_bus_ctrl #(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000,
  parameter logic [21:0] IO_BASE         = io_bus_ctrl_pkg::IO_BASE
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              ioRead,
  input  logic                              ioWrite,
  input  logic [31:0]                       addr,
  input  logic [io_bus_ctrl_pkg::IO_DW-1:0] io_wdata,
  output logic [io_bus_ctrl_pkg::IO_DW-1:0] io_rdata,
  output logic [io_bus_ctrl_pkg::IO_DW-1:0] led,
  input  logic [io_bus_ctrl_pkg::IO_DW-1:0] switch_raw,
  output logic                              sw_changed
);

  import io_bus_ctrl_pkg::*;

  logic             io_hit;
  io_reg_e          reg_sel;
  logic [IO_DW-1:0] led_q;
  logic [IO_DW-1:0] sw_stable;
  logic             sw_changed_q;
  logic             changed_pulse;
  logic             status_rd;
  logic             unused_addr;

  assign unused_addr = ^addr[9:8];
  assign io_hit      = (addr[31:10] == IO_BASE);
  assign reg_sel     = decode_ofs(addr[7:0]);
  assign status_rd   = ioRead && io_hit && (reg_sel == RegStatus);

  switch_debounce #(
    .WIDTH  (IO_DW),
    .CYCLES (32'(DEBOUNCE_CYCLES))
  ) u_debounce (
    .clock         (clock),
    .reset         (reset),
    .raw           (switch_raw),
    .stable        (sw_stable),
    .changed_pulse (changed_pulse)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      led_q        <= '0;
      sw_changed_q <= 1'b0;
    end else begin
      if (ioWrite && io_hit && (reg_sel == RegLed)) led_q <= io_wdata;
      // A new change outranks a coincident status read so no event is lost.
      if (changed_pulse) begin
        sw_changed_q <= 1'b1;
      end else if (status_rd) begin
        sw_changed_q <= 1'b0;
      end
    end
  end

  always_comb begin
    io_rdata = '0;
    if (ioRead && io_hit) begin
      case (reg_sel)
        RegLed:    io_rdata = led_q;
        RegSwitch: io_rdata = sw_stable;
        RegStatus: io_rdata = {{(IO_DW-1){1'b0}}, sw_changed_q};
        default:   io_rdata = '0;
      endcase
    end
  end

  assign led        = led_q;
  assign sw_changed = sw_changed_q;

endmodule

// File: tb/tb_io_bus_ctrl.sv
// Scoreboard bench for io_bus_ctrl: directed scenarios plus random traffic
// checked against a run-length debounce model.
module tb_io_bus_ctrl;

  localparam logic [19:0] DC = 20'd4;
  localparam logic [31:0] A_LED = 32'hFFFFFC60;
  localparam logic [31:0] A_SW  = 32'hFFFFFC70;
  localparam logic [31:0] A_ST  = 32'hFFFFFC74;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ioRead = 1'b0;
  logic        ioWrite = 1'b0;
  logic [31:0] addr = '0;
  logic [23:0] io_wdata = '0;
  logic [23:0] switch_raw = 24'hFFFFFF;
  logic [23:0] io_rdata;
  logic [23:0] led;
  logic        sw_changed;

  int checks = 0;
  int errors = 0;

  logic [23:0] exp_q[$];
  string       nm_q[$];

  // Reference model state
  logic [23:0] m_led = '0, m_stable = '0, m_p1 = '0, m_p2 = '0, run_val = '0;
  int          run_len = 1;
  logic        m_flag = 1'b0;

  logic [21:0] r_hi;
  logic [1:0]  r_mid;
  logic [7:0]  r_ofs;
  logic [7:0]  ofs_tab [5] = '{8'h60, 8'h70, 8'h74, 8'h64, 8'h7C};
  logic [23:0] sw_tab [4] = '{24'h000000, 24'h00000F, 24'hF0F0F0, 24'hFFFFFF};

  io_bus_ctrl #(
    .DEBOUNCE_CYCLES (DC)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .ioRead     (ioRead),
    .ioWrite    (ioWrite),
    .addr       (addr),
    .io_wdata   (io_wdata),
    .io_rdata   (io_rdata),
    .led        (led),
    .switch_raw (switch_raw),
    .sw_changed (sw_changed)
  );

  always #5 clock = ~clock;

  function automatic logic hit(input logic [31:0] a);
    return a[31:10] == 22'h3FFFFF;
  endfunction

  function automatic logic [23:0] m_rdata(input logic [31:0] a);
    if (!hit(a)) return 24'h0;
    case (a[7:0])
      8'h60:   return m_led;
      8'h70:   return m_stable;
      8'h74:   return {23'b0, m_flag};
      default: return 24'h0;
    endcase
  endfunction

  // A switch value is accepted once the synchronised stream has held it for DC+1
  // consecutive samples; reset counts as one sample of zero.
  always @(posedge clock) begin : model
    int          rl;
    logic [23:0] rv;
    logic        set;
    if (reset) begin
      m_led    <= '0;
      m_stable <= '0;
      m_flag   <= 1'b0;
      m_p1     <= '0;
      m_p2     <= '0;
      run_val  <= '0;
      run_len  <= 1;
    end else begin
      rv = run_val;
      rl = run_len;
      if (m_p2 == rv) begin
        rl = rl + 1;
      end else begin
        rv = m_p2;
        rl = 1;
      end
      set = (rl >= int'(DC) + 1) && (m_stable != rv);
      if (set) m_stable <= rv;
      if (ioWrite && hit(addr) && addr[7:0] == 8'h60) m_led <= io_wdata;
      if (set) m_flag <= 1'b1;
      else if (ioRead && hit(addr) && addr[7:0] == 8'h74) m_flag <= 1'b0;
      m_p1    <= switch_raw;
      m_p2    <= m_p1;
      run_val <= rv;
      run_len <= (rl > 1000) ? 1000 : rl;
    end
  end

  task automatic chk(input string nm, input logic [23:0] got, input logic [23:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // Monitor: pins every cycle, read data whenever a read is presented.
  always @(negedge clock) begin
    logic [23:0] e;
    string       n;
    chk("led_pin", led, m_led);
    chk("sw_changed_pin", {23'b0, sw_changed}, {23'b0, m_flag});
    if (ioRead) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_empty: got read %h expected no read", io_rdata);
      end else begin
        e = exp_q.pop_front();
        n = nm_q.pop_front();
        chk(n, io_rdata, e);
      end
    end else begin
      chk("idle_rdata", io_rdata, 24'h0);
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic rd(input logic [31:0] a, input logic [23:0] exp, input string nm);
    exp_q.push_back(exp);
    nm_q.push_back(nm);
    ioRead = 1'b1;
    addr   = a;
    step();
    ioRead = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [23:0] d);
    ioWrite  = 1'b1;
    addr     = a;
    io_wdata = d;
    step();
    ioWrite  = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    switch_raw = 24'hFFFFFF;
    step();
    step();
    chk("reset_led", led, 24'h0);
    chk("reset_flag", {23'b0, sw_changed}, 24'h0);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) rd(A_SW, (i >= int'(DC) + 3) ? 24'hFFFFFF : 24'h0, "reset_sw_lat");

    rd(A_ST, 24'h1, "status_after_reset");
    rd(A_ST, 24'h0, "status_cleared");

    switch_raw = 24'h0;
    repeat (10) step();
    rd(A_ST, 24'h1, "status_zero");
    switch_raw = 24'h00000F;
    for (int i = 0; i < 9; i++) rd(A_SW, (i >= 7) ? 24'h00000F : 24'h0, "deb_latency");
    rd(A_ST, 24'h1, "deb_flag");
    rd(A_ST, 24'h0, "deb_flag_clr");

    switch_raw = 24'h0;
    repeat (3) step();
    switch_raw = 24'h00000F;
    repeat (10) step();
    rd(A_SW, 24'h00000F, "glitch_stable");
    rd(A_ST, 24'h0, "glitch_noflag");

    switch_raw = 24'h00F0F0;
    repeat (6) step();
    rd(A_ST, 24'h0, "race_read");
    rd(A_ST, 24'h1, "race_set_wins");
    rd(A_ST, 24'h0, "race_cleared");
    rd(A_SW, 24'h00F0F0, "race_stable");

    wr(A_LED, 24'hA5A5A5);
    chk("led_write", led, 24'hA5A5A5);
    rd(A_LED, 24'hA5A5A5, "led_rb");
    wr(32'hFFFFFC64, 24'h123456);
    wr(32'h0000FC60, 24'h654321);
    chk("led_miss", led, 24'hA5A5A5);
    ioRead = 1'b1;
    ioWrite = 1'b1;
    addr = A_LED;
    io_wdata = 24'h777777;
    exp_q.push_back(24'hA5A5A5);
    nm_q.push_back("rw_pre_edge");
    step();
    ioRead = 1'b0;
    ioWrite = 1'b0;
    rd(A_LED, 24'h777777, "rw_after");
    rd(32'hFFFFFC7C, 24'h0, "unmapped");
    rd(32'h0000FC70, 24'h0, "miss_sw");
    addr = A_LED;
    step();

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) == 0) switch_raw = sw_tab[$urandom_range(0, 3)];
      r_hi  = ($urandom_range(0, 3) != 0) ? 22'h3FFFFF : 22'($urandom);
      r_mid = 2'($urandom);
      r_ofs = ofs_tab[$urandom_range(0, 4)];
      ioWrite  = ($urandom_range(0, 3) == 0);
      io_wdata = 24'($urandom);
      addr     = {r_hi, r_mid, r_ofs};
      ioRead   = ($urandom_range(0, 2) == 0);
      if (ioRead) begin
        exp_q.push_back(m_rdata(addr));
        nm_q.push_back("rand_read");
      end
      step();
    end
    ioRead = 1'b0;
    ioWrite = 1'b0;
    step();
    chk("queue_drained", 24'(exp_q.size()), 24'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
